// File: rtl/io_cycle_seq_pkg.sv
// rtl/io_cycle_seq_pkg.sv - state encoding and device page constants for the I/O cycle sequencer
package io_cycle_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      WAIT   = 3'd3,
      HOLD   = 3'd4,
      ACK    = 3'd5
   } state_t;

   localparam logic [7:0] SYSDEV_PAGE = 8'h00;
   localparam logic [7:0] IODEV1_PAGE = 8'h01;
   localparam logic [7:0] IODEV2_PAGE = 8'h02;
   localparam logic [7:0] IODEV3_PAGE = 8'h03;

endpackage

// File: rtl/io_cycle_seq_if.sv
// rtl/io_cycle_seq_if.sv - CPU-side single-word request/response port of the I/O cycle sequencer
interface io_cycle_seq_if;

   logic        req;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        ack;
   logic [15:0] rdata;
   logic        timeout;
   logic        busy;

   modport master (output req, wr, addr, wdata, input ack, rdata, timeout, busy);
   modport slave  (input req, wr, addr, wdata, output ack, rdata, timeout, busy);

endinterface

// File: rtl/io_page_decode.sv
// rtl/io_page_decode.sv - active-low device selects from the address page, gated by the I/O strobe
module io_page_decode
   import io_cycle_seq_pkg::*;
(
   input  logic [7:0] page,
   input  logic       nio,
   output logic       nsysdev,
   output logic       niodev1xx,
   output logic       niodev2xx,
   output logic       niodev3xx
);

   assign nsysdev   = !(!nio && (page == SYSDEV_PAGE));
   assign niodev1xx = !(!nio && (page == IODEV1_PAGE));
   assign niodev2xx = !(!nio && (page == IODEV2_PAGE));
   assign niodev3xx = !(!nio && (page == IODEV3_PAGE));

endmodule

// File: rtl/io_cycle_seq.sv
// rtl/io_cycle_seq.sv - turns one CPU request into a full expansion-bus I/O cycle
// with wait-state extension, halt hold-off and wait timeout.
module io_cycle_seq
   import io_cycle_seq_pkg::*;
#(
   parameter int STROBE_CYCLES = 2,
   parameter int WS_MAX        = 15
) (
   input  logic         ec_clk4,
   input  logic         ec_nreset,
   io_cycle_seq_if.slave cpu,
   output logic [15:0]  ec_ab,
   inout  wire  [15:0]  ec_db,
   output logic         ec_nio,
   output logic         ec_nr,
   output logic         ec_nw,
   output logic         ec_nsysdev,
   output logic         ec_niodev1xx,
   output logic         ec_niodev2xx,
   output logic         ec_niodev3xx,
   input  logic         ec_nws,
   input  logic         ec_nhalt
);

   localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
   localparam logic [7:0] WS_LIMIT    = 8'(WS_MAX);

   state_t      state, state_nxt;
   logic        nws_meta, nws_sync, halt_meta, halt_sync;
   logic        wr_q, tmo_q;
   logic [15:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  scnt;
   logic [7:0]  wcnt;
   logic        nio, db_en, ack_c, tmo_c;

   always_ff @(posedge ec_clk4 or negedge ec_nreset) begin
      if (!ec_nreset) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cpu.req && halt_sync) state_nxt = SETUP;
         SETUP:   state_nxt = STROBE;
         STROBE:  if (scnt == STROBE_LAST) state_nxt = nws_sync ? HOLD : WAIT;
         WAIT:    if (nws_sync || (wcnt == WS_LIMIT)) state_nxt = HOLD;
         HOLD:    state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      nio   = 1'b1;
      ec_nr = 1'b1;
      ec_nw = 1'b1;
      db_en = 1'b0;
      ack_c = 1'b0;
      tmo_c = 1'b0;
      case (state)
         SETUP, HOLD: begin
            nio   = 1'b0;
            db_en = wr_q;
         end
         STROBE, WAIT: begin
            nio   = 1'b0;
            db_en = wr_q;
            ec_nr = wr_q;
            ec_nw = !wr_q;
         end
         ACK: begin
            ack_c = 1'b1;
            tmo_c = tmo_q;
         end
         default: ;
      endcase
   end

   // Floating open-drain lines (z/x) count as released.
   always_ff @(posedge ec_clk4 or negedge ec_nreset) begin
      if (!ec_nreset) begin
         nws_meta  <= 1'b1;
         nws_sync  <= 1'b1;
         halt_meta <= 1'b1;
         halt_sync <= 1'b1;
         wr_q      <= 1'b0;
         tmo_q     <= 1'b0;
         addr_q    <= 16'h0000;
         wdata_q   <= 16'h0000;
         rdata_q   <= 16'h0000;
         scnt      <= 4'd0;
         wcnt      <= 8'd1;
      end else begin
         nws_meta  <= (ec_nws !== 1'b0);
         nws_sync  <= nws_meta;
         halt_meta <= (ec_nhalt !== 1'b0);
         halt_sync <= halt_meta;
         if (state == IDLE && state_nxt == SETUP) begin
            wr_q    <= cpu.wr;
            addr_q  <= cpu.addr;
            wdata_q <= cpu.wdata;
            tmo_q   <= 1'b0;
         end
         scnt <= (state == STROBE) ? scnt + 4'd1 : 4'd0;
         wcnt <= (state == WAIT) ? wcnt + 8'd1 : 8'd1;
         if (state == WAIT && !nws_sync && wcnt == WS_LIMIT)
            tmo_q <= 1'b1;
         // Read data is taken while the strobe is still low, on the edge that enters HOLD.
         if ((state == STROBE || state == WAIT) && state_nxt == HOLD && !wr_q)
            rdata_q <= ec_db;
      end
   end

   assign ec_db       = db_en ? wdata_q : 16'hzzzz;
   assign ec_ab       = addr_q;
   assign ec_nio      = nio;
   assign cpu.ack     = ack_c;
   assign cpu.timeout = tmo_c;
   assign cpu.busy    = (state != IDLE);
   assign cpu.rdata   = rdata_q;

   io_page_decode u_decode (
      .page      (addr_q[15:8]),
      .nio       (nio),
      .nsysdev   (ec_nsysdev),
      .niodev1xx (ec_niodev1xx),
      .niodev2xx (ec_niodev2xx),
      .niodev3xx (ec_niodev3xx)
   );

endmodule
